// File: rtl/intr_ctrl_pkg.sv
// Shared FSM encodings and register-offset constants for apb_prio_intr_ctrl.
// Register offsets are added to NUM_INTR to form the word address.
package intr_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ARB  = 3'b010,
        S_WAIT = 3'b100
    } state_e;

    localparam int OFF_ENABLE  = 0;
    localparam int OFF_PENDING = 1;
    localparam int OFF_THRESH  = 2;

endpackage

// File: rtl/intr_prio_arbiter.sv
// Combinational max-priority selector; on equal priority the lowest index wins.
module intr_prio_arbiter #(
    parameter int NUM_INTR = 16,
    parameter int PRIO_W   = 4,
    parameter int ID_W     = 5
) (
    input  logic [NUM_INTR-1:0]        elig_i,
    input  logic [NUM_INTR*PRIO_W-1:0] prio_i,
    output logic [ID_W-1:0]            win_id_o,
    output logic                       any_o
);

    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   best_id;
    logic              found;

    // Strict '>' during the ascending scan keeps the earliest (lowest) index on ties.
    always_comb begin
        best_prio = '0;
        best_id   = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_INTR; i++) begin
            if (elig_i[i] && (!found || (prio_i[i*PRIO_W +: PRIO_W] > best_prio))) begin
                found     = 1'b1;
                best_prio = prio_i[i*PRIO_W +: PRIO_W];
                best_id   = ID_W'(i);
            end
        end
    end

    assign win_id_o = best_id;
    assign any_o    = found;

endmodule

// File: rtl/apb_prio_intr_ctrl.sv
// APB-programmable priority interrupt controller with claim/complete handshake.
// Optional THRESHOLD register is compiled in with the PRIO_THRESHOLD_EN macro.
module apb_prio_intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_INTR = 16,
    parameter int PRIO_W   = 4,
    parameter int ID_W     = 5,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic              pwrite_i,
    input  logic              penable_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              perror_o,
    input  logic [NUM_INTR-1:0] intr_active_i,
    output logic [ID_W-1:0]   intr_to_srvc_o,
    output logic              intr_valid_o,
    input  logic              intr_srvcd_i
);

    localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(NUM_INTR + OFF_ENABLE);
    localparam logic [ADDR_W-1:0] A_PENDING = ADDR_W'(NUM_INTR + OFF_PENDING);

    logic [NUM_INTR*PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_INTR-1:0]        enable_q, enable_d;
    logic [NUM_INTR-1:0]        pending_q, pending_d;
    logic [DATA_W-1:0]          prdata_q, prdata_d;
    logic                       pready_q, pready_d;
    logic                       perror_q, perror_d;
    logic [PRIO_W-1:0]          thresh_cmp;

    state_e          state_q;
    logic [ID_W-1:0] id_q;
    logic            valid_q;

    logic [NUM_INTR-1:0] elig;
    logic [NUM_INTR-1:0] clr_mask;
    logic [ID_W-1:0]     win_id;
    logic                any_elig;
    logic                prio_hit;
    logic                unused_wdata;

    assign unused_wdata = ^pwdata_i;

`ifdef PRIO_THRESHOLD_EN
    localparam logic [ADDR_W-1:0] A_THRESH = ADDR_W'(NUM_INTR + OFF_THRESH);
    logic [PRIO_W-1:0] thresh_q, thresh_d;
    assign thresh_cmp = thresh_q;
`else
    assign thresh_cmp = '0;
`endif

    // An access is performed on the edge where penable_i is high and pready_o is low.
    always_comb begin
        pready_d = penable_i & ~pready_q;
        perror_d = 1'b0;
        prdata_d = prdata_q;
        prio_d   = prio_q;
        enable_d = enable_q;
        prio_hit = 1'b0;
`ifdef PRIO_THRESHOLD_EN
        thresh_d = thresh_q;
`endif
        if (pready_d) begin
            if (!pwrite_i) prdata_d = '0;
            for (int i = 0; i < NUM_INTR; i++) begin
                if (int'(paddr_i) == i) begin
                    prio_hit = 1'b1;
                    if (pwrite_i) prio_d[i*PRIO_W +: PRIO_W] = pwdata_i[PRIO_W-1:0];
                    else          prdata_d = DATA_W'(prio_q[i*PRIO_W +: PRIO_W]);
                end
            end
            if (prio_hit) begin
                perror_d = 1'b0;
            end else if (paddr_i == A_ENABLE) begin
                if (pwrite_i) enable_d = pwdata_i[NUM_INTR-1:0];
                else          prdata_d = DATA_W'(enable_q);
            end else if (paddr_i == A_PENDING) begin
                if (pwrite_i) perror_d = 1'b1;
                else          prdata_d = DATA_W'(pending_q);
`ifdef PRIO_THRESHOLD_EN
            end else if (paddr_i == A_THRESH) begin
                if (pwrite_i) thresh_d = pwdata_i[PRIO_W-1:0];
                else          prdata_d = DATA_W'(thresh_q);
`endif
            end else begin
                perror_d = 1'b1;
            end
        end
    end

    // Set wins over the completion clear, so a still-active source re-pends.
    always_comb begin
        clr_mask  = (state_q == S_WAIT && intr_srvcd_i) ? (NUM_INTR'(1) << id_q) : '0;
        pending_d = (pending_q & ~clr_mask) | (intr_active_i & enable_q);
        for (int i = 0; i < NUM_INTR; i++) begin
            elig[i] = pending_q[i] & enable_q[i] & (prio_q[i*PRIO_W +: PRIO_W] > thresh_cmp);
        end
    end

    intr_prio_arbiter #(
        .NUM_INTR (NUM_INTR),
        .PRIO_W   (PRIO_W),
        .ID_W     (ID_W)
    ) u_arb (
        .elig_i   (elig),
        .prio_i   (prio_q),
        .win_id_o (win_id),
        .any_o    (any_elig)
    );

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            prio_q    <= '0;
            enable_q  <= '0;
            pending_q <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            perror_q  <= 1'b0;
`ifdef PRIO_THRESHOLD_EN
            thresh_q  <= '0;
`endif
        end else begin
            prio_q    <= prio_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            perror_q  <= perror_d;
`ifdef PRIO_THRESHOLD_EN
            thresh_q  <= thresh_d;
`endif
        end
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (any_elig) state_q <= S_ARB;
                S_ARB: begin
                    if (any_elig) begin
                        id_q    <= win_id;
                        valid_q <= 1'b1;
                        state_q <= S_WAIT;
                    end else begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (intr_srvcd_i) begin
                        valid_q <= 1'b0;
                        id_q    <= '0;
                        state_q <= (|(elig & ~clr_mask)) ? S_ARB : S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    id_q    <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign prdata_o       = prdata_q;
    assign pready_o       = pready_q;
    assign perror_o       = perror_q;
    assign intr_to_srvc_o = id_q;
    assign intr_valid_o   = valid_q;

endmodule

// File: tb/tb_apb_prio_intr_ctrl.sv
// Directed bench for apb_prio_intr_ctrl with an expected-id scoreboard.
// Threshold steps are built in when PRIO_THRESHOLD_EN is defined.
module tb_apb_prio_intr_ctrl;

    localparam int NUM_INTR = 16;
    localparam int PRIO_W   = 4;
    localparam int ID_W     = 5;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int A_ENABLE  = NUM_INTR;
    localparam int A_PENDING = NUM_INTR + 1;
    localparam int A_THRESH  = NUM_INTR + 2;

    logic                pclk_i = 1'b0;
    logic                prst_i;
    logic [ADDR_W-1:0]   paddr_i;
    logic [DATA_W-1:0]   pwdata_i;
    logic                pwrite_i;
    logic                penable_i;
    logic [DATA_W-1:0]   prdata_o;
    logic                pready_o;
    logic                perror_o;
    logic [NUM_INTR-1:0] intr_active_i;
    logic [ID_W-1:0]     intr_to_srvc_o;
    logic                intr_valid_o;
    logic                intr_srvcd_i;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    apb_prio_intr_ctrl #(
        .NUM_INTR (NUM_INTR),
        .PRIO_W   (PRIO_W),
        .ID_W     (ID_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .pclk_i         (pclk_i),
        .prst_i         (prst_i),
        .paddr_i        (paddr_i),
        .pwdata_i       (pwdata_i),
        .pwrite_i       (pwrite_i),
        .penable_i      (penable_i),
        .prdata_o       (prdata_o),
        .pready_o       (pready_o),
        .perror_o       (perror_o),
        .intr_active_i  (intr_active_i),
        .intr_to_srvc_o (intr_to_srvc_o),
        .intr_valid_o   (intr_valid_o),
        .intr_srvcd_i   (intr_srvcd_i)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic apb_xfer(input logic wr, input int addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        int cyc;
        paddr_i   = ADDR_W'(addr);
        pwdata_i  = wdata;
        pwrite_i  = wr;
        penable_i = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!pready_o && cyc < 8);
        check("apb_latency", cyc, 1);
        rdata     = prdata_o;
        err       = perror_o;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
    endtask

    task automatic apb_wr(input int addr, input logic [31:0] d, input logic exp_err);
        logic [31:0] r;
        logic        e;
        apb_xfer(1'b1, addr, d, r, e);
        check("wr_err", e, exp_err);
        tick();
    endtask

    task automatic apb_rd(input string tag, input int addr, input logic [31:0] exp_d, input logic exp_err);
        logic [31:0] r;
        logic        e;
        apb_xfer(1'b0, addr, 32'h0, r, e);
        check({tag, "_data"}, r, exp_d);
        check({tag, "_err"}, e, exp_err);
        tick();
    endtask

    task automatic wait_valid(output logic found);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (intr_valid_o) found = 1'b1;
        end
    endtask

    task automatic service();
        logic        found;
        logic [31:0] e;
        wait_valid(found);
        check("deliver_timeout", found, 1);
        check("sb_nonempty", exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("deliver_id", intr_to_srvc_o, e);
        intr_srvcd_i = 1'b1;
        tick();
        intr_srvcd_i = 1'b0;
        check("srvcd_valid_low", intr_valid_o, 0);
        check("srvcd_id_zero", intr_to_srvc_o, 0);
    endtask

    task automatic watch_idle(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (intr_valid_o) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [3:0]  seq;
        logic        found;

        prst_i        = 1'b1;
        paddr_i       = '0;
        pwdata_i      = '0;
        pwrite_i      = 1'b0;
        penable_i     = 1'b0;
        intr_active_i = '0;
        intr_srvcd_i  = 1'b0;

        // Reset state.
        repeat (2) @(posedge pclk_i);
        #1;
        check("rst_prdata", prdata_o, 0);
        check("rst_pready", pready_o, 0);
        check("rst_perror", perror_o, 0);
        check("rst_id", intr_to_srvc_o, 0);
        check("rst_valid", intr_valid_o, 0);
        prst_i = 1'b0;
        tick();
        apb_rd("rst_enable", A_ENABLE, 32'h0, 1'b0);
        apb_rd("rst_pending", A_PENDING, 32'h0, 1'b0);

        // Register access; upper PRIO bits read back as zero.
        apb_wr(3, 32'hABCD_0015, 1'b0);
        apb_rd("prio3", 3, 32'h5, 1'b0);

        // Held penable: one pready pulse every second cycle.
        paddr_i = ADDR_W'(8); pwdata_i = 32'h6; pwrite_i = 1'b1; penable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            seq[i] = pready_o;
        end
        penable_i = 1'b0; pwrite_i = 1'b0;
        check("b2b_pready_seq", seq, 4'b0101);
        tick();
        apb_rd("prio8", 8, 32'h6, 1'b0);

        // Unmapped and read-only addresses.
        apb_wr(63, 32'hFFFF_FFFF, 1'b1);
        apb_rd("unmapped", 63, 32'h0, 1'b1);
        apb_wr(A_PENDING, 32'hFFFF_FFFF, 1'b1);
        apb_rd("pend_after_wr", A_PENDING, 32'h0, 1'b0);
        apb_rd("en_after_wr", A_ENABLE, 32'h0, 1'b0);
`ifndef PRIO_THRESHOLD_EN
        apb_rd("thresh_unmapped", A_THRESH, 32'h0, 1'b1);
`endif

        // Masking: priority 0 enabled source and a non-enabled high source.
        apb_wr(11, 32'h5, 1'b0);
        apb_wr(A_ENABLE, 32'h0000_0001, 1'b0);
        intr_active_i = 16'h0801;
        tick();
        intr_active_i = 16'h0800;
        watch_idle("mask_idle", 12);
        intr_active_i = '0;
        apb_rd("mask_pending", A_PENDING, 32'h0000_0001, 1'b0);

        // Priority order with tie-break to the lowest index.
        apb_wr(2, 32'h7, 1'b0);
        apb_wr(9, 32'h7, 1'b0);
        apb_wr(5, 32'h3, 1'b0);
        apb_wr(A_ENABLE, 32'h0000_0225, 1'b0);
        intr_active_i = 16'h0224;
        tick();
        intr_active_i = '0;
        exp_q.push_back(2);
        exp_q.push_back(9);
        exp_q.push_back(5);
        service();
        service();
        service();
        watch_idle("prio_done_idle", 8);

        // Enabling a held-high source delivers on the third edge after the write edge.
        apb_wr(4, 32'h1, 1'b0);
        intr_active_i = 16'h0010;
        apb_xfer(1'b1, A_ENABLE, 32'h0000_0235, r, e);
        check("en4_err", e, 0);
        tick();
        check("en4_valid_w1", intr_valid_o, 0);
        tick();
        check("en4_valid_w2", intr_valid_o, 0);
        tick();
        check("en4_valid_w3", intr_valid_o, 1);
        check("en4_id_w3", intr_to_srvc_o, 4);

        // PRIO change during WAIT leaves the delivered id alone.
        apb_wr(4, 32'hF, 1'b0);
        apb_wr(A_ENABLE, 32'h0000_0234, 1'b0);
        apb_wr(A_ENABLE, 32'h0000_0235, 1'b0);
        check("wait_hold_valid", intr_valid_o, 1);
        check("wait_hold_id", intr_to_srvc_o, 4);
        exp_q.push_back(4);
        service();

        // Source still high at completion re-pends and is delivered again.
        intr_active_i = '0;
        exp_q.push_back(4);
        service();
        watch_idle("redeliver_done_idle", 10);

        // Reset during WAIT clears the delivery at once.
        intr_active_i = 16'h0010;
        wait_valid(found);
        check("pre_rst_valid", found, 1);
        prst_i = 1'b1;
        #1;
        check("rst_wait_valid", intr_valid_o, 0);
        check("rst_wait_id", intr_to_srvc_o, 0);
        tick();
        prst_i = 1'b0;
        intr_active_i = '0;
        tick();
        apb_rd("post_rst_enable", A_ENABLE, 32'h0, 1'b0);
        apb_rd("post_rst_prio4", 4, 32'h0, 1'b0);
        watch_idle("post_rst_idle", 6);

`ifdef PRIO_THRESHOLD_EN
        // Only priorities strictly above THRESHOLD are delivered.
        apb_wr(A_THRESH, 32'h4, 1'b0);
        apb_rd("thresh", A_THRESH, 32'h4, 1'b0);
        apb_wr(1, 32'h4, 1'b0);
        apb_wr(6, 32'h5, 1'b0);
        apb_wr(A_ENABLE, 32'h0000_0042, 1'b0);
        intr_active_i = 16'h0042;
        tick();
        intr_active_i = '0;
        exp_q.push_back(6);
        service();
        watch_idle("thresh_block_idle", 12);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
